// File: rtl/fetch_decode_pkg.sv
// Shared CHIP-8 front-end definitions: operation codes, reset PC and FSM states.
// Code 31 is reserved and deliberately has no constant; the decoder never emits it.
package fetch_decode_pkg;

  localparam int unsigned ADDR_W_DEF   = 32'd12;
  localparam logic [11:0] PC_RESET_DEF = 12'h200;

  localparam logic [6:0] OP_ILLEGAL  = 7'd0;
  localparam logic [6:0] OP_CLS      = 7'd1;
  localparam logic [6:0] OP_RET      = 7'd2;
  localparam logic [6:0] OP_JP       = 7'd3;
  localparam logic [6:0] OP_CALL     = 7'd4;
  localparam logic [6:0] OP_SE_KK    = 7'd5;
  localparam logic [6:0] OP_SNE_KK   = 7'd6;
  localparam logic [6:0] OP_SE_XY    = 7'd7;
  localparam logic [6:0] OP_LD_KK    = 7'd8;
  localparam logic [6:0] OP_ADD_KK   = 7'd9;
  localparam logic [6:0] OP_ALU_BASE = 7'd10;
  localparam logic [6:0] OP_SHL      = 7'd18;
  localparam logic [6:0] OP_SNE_XY   = 7'd19;
  localparam logic [6:0] OP_LD_I     = 7'd20;
  localparam logic [6:0] OP_JP_V0    = 7'd21;
  localparam logic [6:0] OP_RND      = 7'd22;
  localparam logic [6:0] OP_DRW      = 7'd23;
  localparam logic [6:0] OP_SKP      = 7'd24;
  localparam logic [6:0] OP_SKNP     = 7'd25;
  localparam logic [6:0] OP_LD_VX_DT = 7'd26;
  localparam logic [6:0] OP_LD_VX_K  = 7'd27;
  localparam logic [6:0] OP_LD_DT    = 7'd28;
  localparam logic [6:0] OP_LD_ST    = 7'd29;
  localparam logic [6:0] OP_ADD_I    = 7'd30;
  localparam logic [6:0] OP_LD_F     = 7'd32;
  localparam logic [6:0] OP_LD_B     = 7'd33;
  localparam logic [6:0] OP_LD_MEM   = 7'd34;
  localparam logic [6:0] OP_LD_REG   = 7'd35;

  typedef enum logic [2:0] {
    ST_FETCH_HI,
    ST_FETCH_LO,
    ST_LATCH,
    ST_DECODE,
    ST_ISSUE
  } state_e;

  // 8xy0..8xy7 map onto consecutive codes starting at OP_ALU_BASE
  function automatic logic [6:0] alu_code(input logic [2:0] sel);
    return OP_ALU_BASE + {4'b0000, sel};
  endfunction

endpackage

// File: rtl/chip8_op_decoder.sv
// Purely combinational CHIP-8 instruction decoder: 16-bit opcode to 7-bit
// operation code, with the illegal flag raised whenever the code is 0.
module chip8_op_decoder
  import fetch_decode_pkg::*;
(
  input  logic [15:0] instr,
  output logic [6:0]  code,
  output logic        illegal
);

  logic [3:0] op_s;
  logic [3:0] n_s;
  logic [7:0] kk_s;

  assign op_s = instr[15:12];
  assign n_s  = instr[3:0];
  assign kk_s = instr[7:0];

  // Map the opcode family and its sub-fields onto an operation code
  always_comb begin
    code = OP_ILLEGAL;
    case (op_s)
      4'h0: begin
        if (instr == 16'h00E0)      code = OP_CLS;
        else if (instr == 16'h00EE) code = OP_RET;
        else                        code = OP_ILLEGAL;
      end
      4'h1: code = OP_JP;
      4'h2: code = OP_CALL;
      4'h3: code = OP_SE_KK;
      4'h4: code = OP_SNE_KK;
      4'h5: begin
        if (n_s == 4'h0) code = OP_SE_XY;
        else             code = OP_ILLEGAL;
      end
      4'h6: code = OP_LD_KK;
      4'h7: code = OP_ADD_KK;
      4'h8: begin
        if (n_s[3] == 1'b0)   code = alu_code(n_s[2:0]);
        else if (n_s == 4'hE) code = OP_SHL;
        else                  code = OP_ILLEGAL;
      end
      4'h9: begin
        if (n_s == 4'h0) code = OP_SNE_XY;
        else             code = OP_ILLEGAL;
      end
      4'hA: code = OP_LD_I;
      4'hB: code = OP_JP_V0;
      4'hC: code = OP_RND;
      4'hD: code = OP_DRW;
      4'hE: begin
        case (kk_s)
          8'h9E:   code = OP_SKP;
          8'hA1:   code = OP_SKNP;
          default: code = OP_ILLEGAL;
        endcase
      end
      4'hF: begin
        case (kk_s)
          8'h07:   code = OP_LD_VX_DT;
          8'h0A:   code = OP_LD_VX_K;
          8'h15:   code = OP_LD_DT;
          8'h18:   code = OP_LD_ST;
          8'h1E:   code = OP_ADD_I;
          8'h29:   code = OP_LD_F;
          8'h33:   code = OP_LD_B;
          8'h55:   code = OP_LD_MEM;
          8'h65:   code = OP_LD_REG;
          default: code = OP_ILLEGAL;
        endcase
      end
      default: code = OP_ILLEGAL;
    endcase
    illegal = (code == OP_ILLEGAL);
  end

endmodule

// File: rtl/fetch_decode.sv
// CHIP-8 fetch/decode front end: two-byte fetch, decode, register-file read,
// valid/done handshake with execute, and PC ownership.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int unsigned          ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0]    PC_RESET = ADDR_W'(PC_RESET_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [3:0]        rf_x_addr,
  output logic [3:0]        rf_y_addr,
  input  logic [7:0]        rf_x_data,
  input  logic [7:0]        rf_y_data,
  output logic              instr_valid,
  output logic [6:0]        decode,
  output logic [7:0]        val,
  output logic [3:0]        x,
  output logic [3:0]        y,
  output logic [7:0]        vx,
  output logic [7:0]        vy,
  output logic [11:0]       addr,
  output logic [ADDR_W-1:0] pc,
  output logic              ill_op,
  input  logic              exe_done,
  input  logic              pc_load,
  input  logic [11:0]       pc_target,
  input  logic              pc_skip
);

  state_e            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;
  logic [15:0]       instr_r;
  logic [6:0]        code_s;
  logic              illegal_s;
  logic              instr_valid_r;
  logic [6:0]        decode_r;
  logic [7:0]        val_r;
  logic [3:0]        x_r;
  logic [3:0]        y_r;
  logic [7:0]        vx_r;
  logic [7:0]        vy_r;
  logic [11:0]       addr_r;
  logic              ill_op_r;

  chip8_op_decoder u_dec (
    .instr   (instr_r),
    .code    (code_s),
    .illegal (illegal_s)
  );

  // Read strobe is gated by reset so an abandoned fetch drops the strobe at once
  assign mem_rd    = rst & ((state_r == ST_FETCH_HI) | (state_r == ST_FETCH_LO));
  assign mem_addr  = (state_r == ST_FETCH_LO) ? (pc_r + ADDR_W'(1'b1)) : pc_r;
  assign rf_x_addr = instr_r[11:8];
  assign rf_y_addr = instr_r[7:4];

  // Next PC after retirement: load beats skip, all arithmetic wraps
  always_comb begin
    if (pc_load)      pc_next_s = ADDR_W'(pc_target);
    else if (pc_skip) pc_next_s = pc_r + ADDR_W'(3'd4);
    else              pc_next_s = pc_r + ADDR_W'(2'd2);
  end

  // Fetch/decode/issue sequencer with PC and registered operand outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_FETCH_HI;
      pc_r          <= PC_RESET;
      instr_r       <= 16'h0000;
      instr_valid_r <= 1'b0;
      decode_r      <= 7'd0;
      val_r         <= 8'h00;
      x_r           <= 4'h0;
      y_r           <= 4'h0;
      vx_r          <= 8'h00;
      vy_r          <= 8'h00;
      addr_r        <= 12'h000;
      ill_op_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH_HI: state_r <= ST_FETCH_LO;
        ST_FETCH_LO: begin
          instr_r[15:8] <= mem_rdata;
          state_r       <= ST_LATCH;
        end
        ST_LATCH: begin
          instr_r[7:0] <= mem_rdata;
          state_r      <= ST_DECODE;
        end
        ST_DECODE: begin
          decode_r      <= code_s;
          ill_op_r      <= illegal_s;
          val_r         <= instr_r[7:0];
          x_r           <= instr_r[11:8];
          y_r           <= instr_r[7:4];
          addr_r        <= instr_r[11:0];
          vx_r          <= rf_x_data;
          vy_r          <= rf_y_data;
          instr_valid_r <= 1'b1;
          state_r       <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (exe_done) begin
            instr_valid_r <= 1'b0;
            pc_r          <= pc_next_s;
            state_r       <= ST_FETCH_HI;
          end
        end
        default: begin
          instr_valid_r <= 1'b0;
          state_r       <= ST_FETCH_HI;
        end
      endcase
    end
  end

  assign instr_valid = instr_valid_r;
  assign decode      = decode_r;
  assign val         = val_r;
  assign x           = x_r;
  assign y           = y_r;
  assign vx          = vx_r;
  assign vy          = vy_r;
  assign addr        = addr_r;
  assign pc          = pc_r;
  assign ill_op      = ill_op_r;

endmodule
